// File: rtl/traffic_pkg.sv
// Shared lane indices, widths and bus-slice mapping for the Breadboard lane bus.
package traffic_pkg;
   localparam int NUM_LANES = 8;
   localparam int COUNT_W   = 8;
   localparam int LANE_W    = $clog2(NUM_LANES);

   localparam int LANE_S1 = 0;
   localparam int LANE_S2 = 1;
   localparam int LANE_E1 = 2;
   localparam int LANE_E2 = 3;
   localparam int LANE_N1 = 4;
   localparam int LANE_N2 = 5;
   localparam int LANE_W1 = 6;
   localparam int LANE_W2 = 7;

   typedef enum logic {L_IDLE = 1'b0, L_DRAIN = 1'b1} lane_state_e;

   typedef struct packed {
      logic [LANE_W-1:0]  idx;
      logic [COUNT_W-1:0] cnt;
   } lane_stat_t;

   // Bus order is {W1,W2,S1,S2,E1,E2,N1,N2}, not lane-index order.
   function automatic int lane_offset(input int lane);
      case (lane)
         LANE_S1: lane_offset = 40;
         LANE_S2: lane_offset = 32;
         LANE_E1: lane_offset = 24;
         LANE_E2: lane_offset = 16;
         LANE_N1: lane_offset = 8;
         LANE_N2: lane_offset = 0;
         LANE_W1: lane_offset = 56;
         default: lane_offset = 48;
      endcase
   endfunction
endpackage

// File: rtl/lane_counter.sv
// One lane: waiting-vehicle count with saturation, plus the green-time departure timer.
module lane_counter
   import traffic_pkg::*;
#(
   parameter int DEPART_CYCLES = 4,
   parameter int MAX_COUNT     = 255
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               arrive,
   input  logic               green,
   output logic [COUNT_W-1:0] count,
   output logic [COUNT_W-1:0] count_next
);
   localparam int TW = $clog2(DEPART_CYCLES + 1);

   logic [TW-1:0] timer, timer_next;
   lane_state_e   state;
   logic          dep;

   always_comb begin
      state = (green && count != '0) ? L_DRAIN : L_IDLE;
      dep   = (state == L_DRAIN) && (timer == TW'(DEPART_CYCLES - 1));
   end

   // Leaving DRAIN discards partial progress, so a re-green waits a full period.
   always_comb begin
      timer_next = '0;
      if (!clear && state == L_DRAIN && !dep)
         timer_next = timer + 1'b1;
   end

   always_comb begin
      count_next = count;
      if (clear)
         count_next = '0;
      else if (arrive && !dep) begin
         if (count < COUNT_W'(MAX_COUNT))
            count_next = count + 1'b1;
      end else if (dep && !arrive)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
         timer <= '0;
      end else begin
         count <= count_next;
         timer <= timer_next;
      end
   end
endmodule

// File: rtl/lane_queue_tracker.sv
// Per-lane queue counts packed onto the Breadboard lane bus, plus busiest-lane report.
module lane_queue_tracker
   import traffic_pkg::*;
#(
   parameter int DEPART_CYCLES = 4,
   parameter int MAX_COUNT     = 255
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clear,
   input  logic [NUM_LANES-1:0]           arrive,
   input  logic [NUM_LANES-1:0]           greenIn,
   output logic [NUM_LANES*COUNT_W-1:0]   lanes,
   output logic [LANE_W-1:0]              maxLane,
   output logic [COUNT_W-1:0]             maxCount,
   output logic                           anyWaiting
);
   logic [NUM_LANES-1:0][COUNT_W-1:0] cnt, cnt_nxt;
   lane_stat_t                        best;
   logic                              any_nxt;

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      lane_counter #(
         .DEPART_CYCLES (DEPART_CYCLES),
         .MAX_COUNT     (MAX_COUNT)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .clear      (clear),
         .arrive     (arrive[g]),
         .green      (greenIn[g]),
         .count      (cnt[g]),
         .count_next (cnt_nxt[g])
      );
   end

   always_comb begin
      lanes = '0;
      for (int k = 0; k < NUM_LANES; k++)
         lanes[lane_offset(k) +: COUNT_W] = cnt[k];
   end

   // Strict '>' keeps the lowest index on ties; all-zero falls out as lane 0, count 0.
   always_comb begin
      best.idx = '0;
      best.cnt = cnt_nxt[0];
      any_nxt  = 1'b0;
      for (int k = 0; k < NUM_LANES; k++) begin
         any_nxt = any_nxt | (cnt_nxt[k] != '0);
         if (cnt_nxt[k] > best.cnt) begin
            best.idx = LANE_W'(k);
            best.cnt = cnt_nxt[k];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         maxLane    <= '0;
         maxCount   <= '0;
         anyWaiting <= 1'b0;
      end else begin
         maxLane    <= best.idx;
         maxCount   <= best.cnt;
         anyWaiting <= any_nxt;
      end
   end
endmodule

// File: doc/lane_queue_tracker.md
Name: lane_queue_tracker

Overview:
- Upstream stage of the Breadboard controller. Maintains the per-lane waiting-vehicle counts that Breadboard consumes as its packed 64-bit lane bus.
- Counts arrivals from per-lane vehicle sensor pulses.
- Counts departures from the controller's own trafficLightOutput, fed back: a green lane discharges one vehicle every DEPART_CYCLES clocks.
- Also reports the busiest lane for emergency/priority logic.

Parameters:
- DEPART_CYCLES, 4, clocks per departed vehicle while a lane is green (>=1).
- MAX_COUNT, 255, saturation ceiling per lane (<=255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of all counts and timers
- arrive  in  8  one-cycle pulse per vehicle arriving; bit k = lane k
- greenIn  in  8  trafficLightOutput from Breadboard; bit k high = lane k green
- lanes  out  64  packed counts {W1,W2,S1,S2,E1,E2,N1,N2}, 8 bits each
- maxLane  out  3  index of lane with largest count
- maxCount  out  8  count of maxLane
- anyWaiting  out  1  high when any count nonzero

Behaviour:
- Lane index map (k = greenIn/arrive bit): 0=S1, 1=S2, 2=E1, 3=E2, 4=N1, 5=N2, 6=W1, 7=W2.
- Bus slices:
  - W1 [63:56], W2 [55:48], S1 [47:40], S2 [39:32]
  - E1 [31:24], E2 [23:16], N1 [15:8], N2 [7:0]
- Reset (rst=0, async): all counts 0, all timers 0, lanes=0, maxLane=0, maxCount=0, anyWaiting=0.
- Per lane, a timer of width clog2(DEPART_CYCLES+1) with two states:
  - IDLE: greenIn[k]=0, or count=0. Timer held at 0.
  - DRAIN: greenIn[k]=1 and count>0. Timer increments each cycle. On reaching DEPART_CYCLES-1, departs one vehicle and timer wraps to 0.
  - With DEPART_CYCLES=1, one departure per green cycle.
- Green deassert mid-count: timer resets to 0 next cycle. Partial progress is lost, no departure.
- Green reasserted later: the first departure comes a full DEPART_CYCLES after the reassert.
- Count update each cycle: next = count + arr - dep.
  - arr=1 and dep=1 together: count unchanged (timer still wraps).
  - arr=1 at MAX_COUNT with no departure: count holds MAX_COUNT, arrival dropped.
  - dep only fires when count>0; count never underflows.
  - When count reaches 0, timer returns to 0 and the lane goes IDLE.
- clear=1: counts and timers go to 0 next edge, overriding simultaneous arrivals and departures.
- Latency: lanes is registered. An arrive pulse at edge t appears on lanes after edge t.
- maxLane, maxCount, anyWaiting are registered from the updated counts, in the same cycle as lanes (no extra latency).
  - Ties resolve to the lowest index.
  - All counts zero: maxLane=0, maxCount=0, anyWaiting=0.
- Multiple lanes may be green at once; each drains independently.
- Sustained arrive high: counts one vehicle per cycle. No edge detection is done; sensors guarantee pulses.

Decomposition:
- Shared package, traffic_pkg:
  - lane index constants LANE_S1..LANE_W2
  - NUM_LANES=8, COUNT_W=8
  - function mapping lane index to bus slice offset, reused by Breadboard and the bench.
- One natural sub-module: lane_counter, which holds a single lane's count, timer and saturation logic. It is instantiated 8x via generate.
- The top level holds the bus packing and the max-lane comparator tree.

Test Plan:
1. Reset, then arrive[0] pulsed 7 cycles with greenIn=0 -> lanes[47:40]=7, maxLane=0, maxCount=7, anyWaiting=1; all other slices 0.
2. S1=7, then greenIn=8'h01 for 12 cycles with DEPART_CYCLES=4 -> S1 decrements at cycles 4, 8, 12, reaching 4. Drop green at cycle 14 and reassert -> next departure 4 cycles after the reassert.
3. W2 at 255, arrive[7] pulsed 3 more times with greenIn=0 -> lanes[55:48] stays 8'hFF. Green W2 with arrive[7] held high -> count stays 255 (simultaneous arrive and depart).
4. N1=3 and E2=3 (tie) -> maxLane=3 (E2, lower index). Then one arrival on N1 -> maxLane=4, maxCount=4.
5. Counts nonzero, rst pulsed low mid-DRAIN, asynchronous to clk -> all outputs 0 immediately. After release, the first departure needs a full DEPART_CYCLES.
6. clear=1 asserted in the same cycle as arrive=8'hFF and greenIn=8'hFF -> lanes=0, anyWaiting=0 on the next edge.
